// File: rtl/row_product_scheduler_pkg.sv
// Shared types and default sizing for the row-product scheduler and its watchdog.
package row_product_scheduler_pkg;

  localparam int ELEMENT_WIDTH  = 32;
  localparam int NO_OF_UNITS    = 256;
  localparam int MAX_ROWS       = 256;
  localparam int CHUNKS_PER_ROW = 4;
  localparam int TIMEOUT_CYCLES = 1024;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_READ,
    S_LOAD,
    S_WAIT_EXE,
    S_WAIT_FINAL,
    S_WRITE,
    S_DONE,
    S_ERROR
  } sched_state_e;

endpackage

// File: rtl/row_product_scheduler_watchdog.sv
// Wait-state watchdog: counts enabled cycles and flags the last allowed one.
module sched_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)   count_d = '0;
    else if (en_i) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign expire_o = en_i && (count_q == LAST);

endmodule

// File: rtl/row_product_scheduler.sv
// Drives the row adder organizer chunk by chunk over every row of a matrix-vector
// product and writes each finished row sum to result memory.
module row_product_scheduler
  import row_product_scheduler_pkg::*;
#(
  parameter int element_width  = ELEMENT_WIDTH,
  parameter int no_of_units    = NO_OF_UNITS,
  parameter int max_rows       = MAX_ROWS,
  parameter int chunks_per_row = CHUNKS_PER_ROW,
  parameter int timeout_cycles = TIMEOUT_CYCLES,
  localparam int RW = $clog2(max_rows),
  localparam int CW = (chunks_per_row > 1) ? $clog2(chunks_per_row) : 1,
  localparam int DW = no_of_units * element_width
) (
  input  logic                     clk,
  input  logic                     main_reset_n,
  input  logic                     go,
  input  logic                     abort,
  input  logic [RW:0]              n_rows,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     mem_rd_en,
  output logic [RW+CW-1:0]         mem_rd_addr,
  input  logic [DW-1:0]            mem_rd_data,
  output logic [DW-1:0]            org_row_input,
  output logic                     org_start,
  output logic                     org_outsider4,
  output logic                     org_main_reset,
  input  logic                     org_exe_finish,
  input  logic                     org_final_finish,
  input  logic [element_width-1:0] org_adder_output,
  output logic                     res_we,
  output logic [RW-1:0]            res_addr,
  output logic [element_width-1:0] res_data
);

  sched_state_e             state_q, state_d;
  logic [RW-1:0]            row_q, row_d;
  logic [CW-1:0]            chunk_q, chunk_d;
  logic [RW:0]              nRows_q, nRows_d;
  logic [element_width-1:0] sum_q, sum_d;
  logic [DW-1:0]            rowInput_q, rowInput_d;
  logic                     outsider_q, outsider_d;
  logic                     errFlag_q, errFlag_d;
  logic                     orgClr_q, orgClr_d;
  logic                     goPrev_q;

  logic goAccept, lastChunk, lastRow, waiting, wdExpire;

  // Only a fresh rising edge of go starts a run, so a held go cannot relaunch after done.
  assign goAccept  = go && !goPrev_q;
  assign lastChunk = (chunk_q == CW'(chunks_per_row - 1));
  assign lastRow   = ({1'b0, row_q} == (nRows_q - (RW+1)'(1)));
  assign waiting   = (state_q == S_WAIT_EXE) || (state_q == S_WAIT_FINAL);

  sched_watchdog #(.LIMIT(timeout_cycles)) u_watchdog (
    .clk_i    (clk),
    .rst_n_i  (main_reset_n),
    .clear_i  (state_d != state_q),
    .en_i     (waiting),
    .expire_o (wdExpire)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    chunk_d    = chunk_q;
    nRows_d    = nRows_q;
    sum_d      = sum_q;
    rowInput_d = rowInput_q;
    errFlag_d  = errFlag_q;
    outsider_d = 1'b0;
    orgClr_d   = 1'b0;
    if (state_q != S_IDLE && abort) begin
      state_d  = S_IDLE;
      orgClr_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (goAccept) begin
          nRows_d   = n_rows;
          row_d     = '0;
          errFlag_d = 1'b0;
          state_d   = (n_rows == '0) ? S_DONE : S_CLEAR;
        end
        S_CLEAR: begin
          chunk_d = '0;
          state_d = S_READ;
        end
        S_READ: state_d = S_LOAD;
        S_LOAD: begin
          rowInput_d = mem_rd_data;
          outsider_d = 1'b1;
          state_d    = S_WAIT_EXE;
        end
        // A finish arriving on the expiry cycle still counts as success.
        S_WAIT_EXE: begin
          if (org_exe_finish) begin
            if (lastChunk) state_d = S_WAIT_FINAL;
            else begin
              chunk_d = chunk_q + CW'(1);
              state_d = S_READ;
            end
          end else if (wdExpire) begin
            errFlag_d = 1'b1;
            state_d   = S_ERROR;
          end
        end
        S_WAIT_FINAL: begin
          if (org_final_finish) begin
            sum_d   = org_adder_output;
            state_d = S_WRITE;
          end else if (wdExpire) begin
            errFlag_d = 1'b1;
            state_d   = S_ERROR;
          end
        end
        S_WRITE: begin
          if (lastRow) state_d = S_DONE;
          else begin
            row_d   = row_q + RW'(1);
            state_d = S_CLEAR;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!main_reset_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      chunk_q    <= '0;
      nRows_q    <= '0;
      sum_q      <= '0;
      rowInput_q <= '0;
      outsider_q <= 1'b0;
      errFlag_q  <= 1'b0;
      orgClr_q   <= 1'b1;
      goPrev_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      chunk_q    <= chunk_d;
      nRows_q    <= nRows_d;
      sum_q      <= sum_d;
      rowInput_q <= rowInput_d;
      outsider_q <= outsider_d;
      errFlag_q  <= errFlag_d;
      orgClr_q   <= orgClr_d;
      goPrev_q   <= go;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE) && !abort;
  assign error          = errFlag_q;
  assign mem_rd_en      = (state_q == S_READ);
  assign mem_rd_addr    = {row_q, chunk_q};
  assign org_row_input  = rowInput_q;
  assign org_start      = (state_q inside {S_LOAD, S_WAIT_EXE, S_WAIT_FINAL, S_WRITE}) ||
                          ((state_q == S_READ) && (chunk_q != '0));
  assign org_outsider4  = outsider_q;
  assign org_main_reset = orgClr_q || (state_q == S_CLEAR) || (state_q == S_ERROR);
  assign res_we         = (state_q == S_WRITE) && !abort;
  assign res_addr       = row_q;
  assign res_data       = sum_q;

endmodule
